// File: rtl/holo_pkg.sv
// rtl/holo_pkg.sv - HoloRiscV shared types: fetch states, fetch constants, core stage and opcode constants
package holo_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ERR   = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    STAGE_FETCH   = 3'd0,
    STAGE_DECODE  = 3'd1,
    STAGE_EXECUTE = 3'd2,
    STAGE_MEMORY  = 3'd3,
    STAGE_WRITEBK = 3'd4
  } core_stage_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/holo_fetch_buf.sv
// rtl/holo_fetch_buf.sv - one-entry word/pc holding register with load, pop and flush
module holo_fetch_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [31:0]       i_word,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_valid,
  output logic [31:0]       o_word,
  output logic [ADDR_W-1:0] o_pc
);
  logic              r_valid;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_word  <= i_word;
      r_pc    <= i_pc;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_word  = r_word;
  assign o_pc    = r_pc;
endmodule

// File: rtl/holo_fetch.sv
// rtl/holo_fetch.sv - byte-serial RV32I instruction fetch to DECODE; prefetch buffer under HOLO_FETCH_PREFETCH_EN
module holo_fetch
  import holo_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_oe,
  input  logic [7:0]        instr_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [31:0]       ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              fetch_err
);
  fetch_state_t      r_state, w_next_state;
  logic              r_busy, r_data_vld, r_oe;
  logic [2:0]        r_issue_k;
  logic [1:0]        r_cap_k;
  logic [23:0]       r_asm;
  logic [ADDR_W-1:0] r_fpc, r_addr, r_ir_pc;
  logic [31:0]       r_ir_data;
  logic              w_hs, w_done, w_bad, w_to_ir, w_start, w_prefetch;
  logic [ADDR_W-1:0] w_start_pc;
  logic [31:0]       w_word;
  logic              w_buf_valid;
  logic [31:0]       w_buf_word;
  logic [ADDR_W-1:0] w_buf_pc;

  assign w_hs    = (r_state == ST_HOLD) && ir_ready;
  assign w_done  = r_busy && r_data_vld && (r_cap_k == 2'd3);
  assign w_bad   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_word  = {instr_data, r_asm};
  // A finished word goes to the IR when the IR is empty or being consumed this edge.
  assign w_to_ir = w_done && ((r_state == ST_FETCH) || w_hs);

`ifdef HOLO_FETCH_PREFETCH_EN
  assign w_prefetch = 1'b1;
  holo_fetch_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_done && (r_state == ST_HOLD) && !w_hs && !redirect_valid),
    .i_pop   (w_hs && w_buf_valid),
    .i_flush (redirect_valid),
    .i_word  (w_word),
    .i_pc    (r_fpc),
    .o_valid (w_buf_valid),
    .o_word  (w_buf_word),
    .o_pc    (w_buf_pc)
  );
`else
  assign w_prefetch  = 1'b0;
  assign w_buf_valid = 1'b0;
  assign w_buf_word  = '0;
  assign w_buf_pc    = '0;
`endif

  // A new word starts issuing byte 0 at the same edge that triggers it.
  always_comb begin
    w_start    = 1'b0;
    w_start_pc = r_fpc;
    if (redirect_valid) begin
      w_start    = !w_bad;
      w_start_pc = redirect_pc;
    end else if (w_hs && !r_busy) begin
      w_start    = 1'b1;
      w_start_pc = r_fpc;
    end else if (w_to_ir && w_prefetch) begin
      w_start    = 1'b1;
      w_start_pc = r_fpc + ADDR_W'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (redirect_valid) begin
      w_next_state = w_bad ? ST_ERR : ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: if (w_done) w_next_state = ST_HOLD;
        ST_HOLD:  if (w_hs && !w_buf_valid && !w_done) w_next_state = ST_FETCH;
        default:  w_next_state = ST_ERR;
      endcase
    end
  end

  always_comb begin
    instr_addr = r_addr;
    instr_oe   = r_oe;
    ir_valid   = (r_state == ST_HOLD);
    ir_data    = r_ir_data;
    ir_pc      = r_ir_pc;
    fetch_err  = (r_state == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b1;
      r_issue_k  <= 3'd0;
      r_cap_k    <= 2'd0;
      r_data_vld <= 1'b0;
      r_asm      <= '0;
      r_fpc      <= RESET_PC;
      r_addr     <= RESET_PC;
      r_oe       <= 1'b0;
    end else if (w_start) begin
      r_busy     <= 1'b1;
      r_fpc      <= w_start_pc;
      r_addr     <= w_start_pc;
      r_oe       <= 1'b1;
      r_issue_k  <= 3'd1;
      r_cap_k    <= 2'd0;
      r_data_vld <= 1'b0;
    end else if (redirect_valid) begin
      r_busy     <= 1'b0;
      r_fpc      <= redirect_pc;
      r_oe       <= 1'b0;
      r_issue_k  <= 3'd0;
      r_cap_k    <= 2'd0;
      r_data_vld <= 1'b0;
    end else begin
      r_data_vld <= r_oe;
      if (w_done) begin
        r_busy <= 1'b0;
        r_fpc  <= r_fpc + ADDR_W'(INSTR_BYTES);
        r_oe   <= 1'b0;
      end else if (r_busy && (r_issue_k < 3'(INSTR_BYTES))) begin
        r_addr    <= r_fpc + ADDR_W'(r_issue_k);
        r_oe      <= 1'b1;
        r_issue_k <= r_issue_k + 3'd1;
      end else begin
        r_oe <= 1'b0;
      end
      if (r_data_vld) begin
        r_cap_k <= r_cap_k + 2'd1;
        case (r_cap_k)
          2'd0:    r_asm[7:0]   <= instr_data;
          2'd1:    r_asm[15:8]  <= instr_data;
          2'd2:    r_asm[23:16] <= instr_data;
          default: r_asm        <= r_asm;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_data <= '0;
      r_ir_pc   <= RESET_PC;
    end else if (!redirect_valid) begin
      if (w_to_ir) begin
        r_ir_data <= w_word;
        r_ir_pc   <= r_fpc;
      end else if (w_hs && w_buf_valid) begin
        r_ir_data <= w_buf_word;
        r_ir_pc   <= w_buf_pc;
      end
    end
  end
endmodule
